// File: rtl/trace_ram_arbiter.sv
// trace_ram_arbiter: write-port controller for the shared trace RAM.
// Sequences capture sessions (arm, run, stop-on-full or circular wrap) and
// arbitrates a single RAM write port between host writes and buffered
// capture events. Host writes always win; capture events wait in a small FIFO.
//
// state  | meaning
// -------+--------------------------------------------------------------
// S_IDLE | no session; capture strobes ignored, counters hold for readback
// S_RUN  | capturing; events buffered and written at the capture address
// S_DONE | stop-mode session filled the RAM; strobes ignored until cap_en=0

module trace_ram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_waddr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              cap_en,
  input  logic              cap_wrap,
  input  logic              cap_valid,
  input  logic [DATA_W-1:0] cap_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W:0]   cap_count,
  output logic [1:0]        cap_state,
  output logic              cap_overflow,
  output logic              cap_wrapped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [ADDR_W:0] COUNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] COUNT_LAST = COUNT_FULL - (ADDR_W+1)'(1);
  localparam logic [PTR_W:0]  FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } cap_state_t;

  cap_state_t state_q, state_d;

  logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [PTR_W:0]    fifo_cnt;

  logic              wrap_mode_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [ADDR_W:0]   cap_count_q;
  logic              overflow_q;
  logic              wrapped_q;

  logic run, fifo_empty, fifo_full;
  logic pop, push_req, push, drop, start, flush;

  assign run        = (state_q == S_RUN);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FIFO_FULL_CNT);

  // Host has absolute priority; a capture pop only uses otherwise idle cycles.
  assign pop      = run && !host_we && !fifo_empty;
  assign push_req = run && cap_valid;
  // A full FIFO still accepts an event when its head leaves the same cycle.
  assign push     = push_req && (!fifo_full || pop);
  assign drop     = push_req && !push;
  assign start    = (state_q == S_IDLE) && cap_en;
  // Buffered events only survive while the session stays in RUN.
  assign flush    = !(run && (state_d == S_RUN));

  // Session state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stop mode ends the session on the pop that fills the RAM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cap_en) state_d = S_RUN;
      S_RUN: begin
        if (!cap_en)
          state_d = S_IDLE;
        else if (!wrap_mode_q && pop && (cap_count_q == COUNT_LAST))
          state_d = S_DONE;
      end
      S_DONE: if (!cap_en) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Event buffer storage; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cap_data;
  end

  // Event buffer pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Session bookkeeping: capture address, event count and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_mode_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_count_q <= '0;
      overflow_q  <= 1'b0;
      wrapped_q   <= 1'b0;
    end else if (start) begin
      wrap_mode_q <= cap_wrap;
      cap_addr_q  <= '0;
      cap_count_q <= '0;
      overflow_q  <= 1'b0;
      wrapped_q   <= 1'b0;
    end else begin
      if (pop) begin
        cap_addr_q <= cap_addr_q + ADDR_W'(1);
        // A full count on a pop means the address has already wrapped once.
        if (cap_count_q == COUNT_FULL) wrapped_q   <= 1'b1;
        else                           cap_count_q <= cap_count_q + (ADDR_W+1)'(1);
      end
      if (drop) overflow_q <= 1'b1;
    end
  end

  // Registered RAM write port; address/data hold when no write is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we    <= 1'b0;
      ram_waddr <= '0;
      ram_wdata <= '0;
    end else begin
      ram_we <= host_we || pop;
      if (host_we) begin
        ram_waddr <= host_waddr;
        ram_wdata <= host_wdata;
      end else if (pop) begin
        ram_waddr <= cap_addr_q;
        ram_wdata <= fifo_mem[rd_ptr];
      end
    end
  end

  assign cap_count    = cap_count_q;
  assign cap_state    = state_q;
  assign cap_overflow = overflow_q;
  assign cap_wrapped  = wrapped_q;

endmodule

// File: tb/tb_trace_ram_arbiter.sv
// Bench for trace_ram_arbiter with a 16-word RAM (ADDR_W=4) so the
// stop-on-full and wrap sessions are short. Expected RAM writes (address,
// data, cycle) are queued by the stimulus; a negedge monitor pops and checks
// every ram_we pulse. Status outputs are checked directly by the stimulus.

module tb_trace_ram_arbiter;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          host_we;
  logic [AW-1:0] host_waddr;
  logic [DW-1:0] host_wdata;
  logic          cap_en;
  logic          cap_wrap;
  logic          cap_valid;
  logic [DW-1:0] cap_data;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW:0]   cap_count;
  logic [1:0]    cap_state;
  logic          cap_overflow;
  logic          cap_wrapped;

  trace_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .rst          (rst),
    .host_we      (host_we),
    .host_waddr   (host_waddr),
    .host_wdata   (host_wdata),
    .cap_en       (cap_en),
    .cap_wrap     (cap_wrap),
    .cap_valid    (cap_valid),
    .cap_data     (cap_data),
    .ram_we       (ram_we),
    .ram_waddr    (ram_waddr),
    .ram_wdata    (ram_wdata),
    .cap_count    (cap_count),
    .cap_state    (cap_state),
    .cap_overflow (cap_overflow),
    .cap_wrapped  (cap_wrapped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every RAM write must match the head of the expected queue.
  always @(negedge clk) begin
    exp_t e;
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %0h data %0h want no write (cycle %0d)",
                 ram_waddr, ram_wdata, cyc);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(ram_waddr), 32'(e.addr));
        chk("wr_data", ram_wdata, e.data);
        chk("wr_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // Drop to IDLE, then arm a fresh session; returns with the DUT in RUN.
  task automatic new_session(input logic wrap);
    cap_en = 1'b0;
    ticks(2);
    cap_wrap = wrap;
    cap_en   = 1'b1;
    tick();
  endtask

  task automatic check_status(input string tag, input int cnt, input int st,
                              input logic ov, input logic wr);
    chk({tag, "_count"},    32'(cap_count),    32'(cnt));
    chk({tag, "_state"},    32'(cap_state),    32'(st));
    chk({tag, "_overflow"}, 32'(cap_overflow), 32'(ov));
    chk({tag, "_wrapped"},  32'(cap_wrapped),  32'(wr));
  endtask

  initial begin
    int n;
    rst        = 1'b1;
    host_we    = 1'b0;
    host_waddr = '0;
    host_wdata = '0;
    cap_en     = 1'b0;
    cap_wrap   = 1'b0;
    cap_valid  = 1'b0;
    cap_data   = '0;
    ticks(3);

    // Reset state
    chk("rst_ram_we",    32'(ram_we),    32'd0);
    chk("rst_ram_waddr", 32'(ram_waddr), 32'd0);
    chk("rst_ram_wdata", ram_wdata,      32'd0);
    check_status("rst", 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    ticks(2);

    // Host write only (address 0x0123 truncated to the 4-bit RAM)
    expect_wr(4'h3, 32'hDEADBEEF, cyc + 1);
    host_we    = 1'b1;
    host_waddr = 4'h3;
    host_wdata = 32'hDEADBEEF;
    tick();
    host_we = 1'b0;
    ticks(3);
    check_status("host", 0, 0, 1'b0, 1'b0);

    // Basic capture: three events two cycles apart
    new_session(1'b0);
    for (int i = 0; i < 3; i++) begin
      expect_wr(AW'(i), 32'hA1 + i, cyc + 2);
      cap_valid = 1'b1;
      cap_data  = 32'hA1 + i;
      tick();
      cap_valid = 1'b0;
      tick();
    end
    ticks(3);
    check_status("basic", 3, 1, 1'b0, 1'b0);
    cap_en = 1'b0;
    ticks(2);
    check_status("basic_idle", 3, 0, 1'b0, 1'b0);

    // Conflict: host writes on four cycles starting with the capture strobe
    new_session(1'b0);
    n = cyc;
    for (int j = 0; j < 4; j++) expect_wr(AW'(5 + j), 32'h1000 + j, n + 1 + j);
    expect_wr(4'h0, 32'hC0, n + 5);
    for (int j = 0; j < 4; j++) begin
      host_we    = 1'b1;
      host_waddr = AW'(5 + j);
      host_wdata = 32'h1000 + j;
      cap_valid  = (j == 0);
      cap_data   = 32'hC0;
      tick();
    end
    host_we   = 1'b0;
    cap_valid = 1'b0;
    ticks(4);
    check_status("conflict", 1, 1, 1'b0, 1'b0);

    // Overflow: host holds the port 8 cycles while 6 events arrive
    new_session(1'b0);
    n = cyc;
    for (int j = 0; j < 8; j++) expect_wr(AW'(8 + j), 32'h2000 + j, n + 1 + j);
    for (int i = 0; i < 4; i++) expect_wr(AW'(i), 32'hE0 + i, n + 9 + i);
    for (int j = 0; j < 8; j++) begin
      host_we    = 1'b1;
      host_waddr = AW'(8 + j);
      host_wdata = 32'h2000 + j;
      cap_valid  = (j < 6);
      cap_data   = 32'hE0 + j;
      tick();
    end
    host_we   = 1'b0;
    cap_valid = 1'b0;
    ticks(6);
    check_status("overflow", 4, 1, 1'b1, 1'b0);

    // Stop on full: 20 events, only the first 16 are written
    new_session(1'b0);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) expect_wr(AW'(i), 32'h300 + i, cyc + 2);
      cap_valid = 1'b1;
      cap_data  = 32'h300 + i;
      tick();
      cap_valid = 1'b0;
      tick();
    end
    ticks(2);
    check_status("stop", 16, 2, 1'b0, 1'b0);
    cap_en = 1'b0;
    ticks(2);
    chk("stop_idle_state", 32'(cap_state), 32'd0);

    // Wrap: 18 events, the 17th and 18th land at addresses 0 and 1
    new_session(1'b1);
    for (int i = 0; i < 16; i++) begin
      expect_wr(AW'(i), 32'h400 + i, cyc + 2);
      cap_valid = 1'b1;
      cap_data  = 32'h400 + i;
      tick();
      cap_valid = 1'b0;
      tick();
    end
    tick();
    check_status("wrap16", 16, 1, 1'b0, 1'b0);
    for (int i = 16; i < 18; i++) begin
      expect_wr(AW'(i), 32'h400 + i, cyc + 2);
      cap_valid = 1'b1;
      cap_data  = 32'h400 + i;
      tick();
      cap_valid = 1'b0;
      tick();
    end
    tick();
    check_status("wrap18", 16, 1, 1'b0, 1'b1);

    // Reset mid-burst: buffered event and simultaneous host write are cancelled
    cap_valid = 1'b1;
    cap_data  = 32'h500;
    tick();
    cap_valid  = 1'b0;
    rst        = 1'b1;
    cap_en     = 1'b0;
    host_we    = 1'b1;
    host_waddr = 4'h9;
    host_wdata = 32'h600;
    tick();
    chk("midrst_ram_we",    32'(ram_we),    32'd0);
    chk("midrst_ram_waddr", 32'(ram_waddr), 32'd0);
    check_status("midrst", 0, 0, 1'b0, 1'b0);
    rst     = 1'b0;
    host_we = 1'b0;
    ticks(4);
    check_status("postrst", 0, 0, 1'b0, 1'b0);

    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_ram_arbiter.md
Name: trace_ram_arbiter

Overview:
Write-port controller for the 16K x 32 block RAM shared between the JTAG host write path and the TAP-signal timing logger. It sequences capture sessions (arm, run, stop-on-full or circular wrap) and arbitrates one RAM write port between synchronized host writes and buffered capture events. It sits between the clock-domain synchronizers/logger and the RAM, replacing the ad-hoc tmode mux in system.v.

Parameters:
ADDR_W, 14, RAM word address width (depth 2^ADDR_W)
DATA_W, 32, RAM word width
FIFO_DEPTH, 4, capture event buffer entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
host_we  in  1  single-cycle host write strobe, already synchronized and edge-detected
host_waddr  in  ADDR_W  host write address, valid with host_we
host_wdata  in  DATA_W  host write data, valid with host_we
cap_en  in  1  capture mode enable (level, from flags bit 16)
cap_wrap  in  1  1 = circular buffer, 0 = stop when full; sampled at session start
cap_valid  in  1  capture event strobe (one cycle per event)
cap_data  in  DATA_W  event word {timer[23:0], tapsigs[7:0]}
ram_we  out  1  RAM write enable (registered)
ram_waddr  out  ADDR_W  RAM write address (registered)
ram_wdata  out  DATA_W  RAM write data (registered)
cap_count  out  ADDR_W+1  events written this session, saturates at 2^ADDR_W
cap_state  out  2  0 IDLE, 1 RUN, 2 DONE
cap_overflow  out  1  sticky: event dropped because FIFO full
cap_wrapped  out  1  sticky: circular session wrote past last address

Behaviour:
- Reset: all outputs 0, state IDLE, FIFO empty, capture address 0, latched wrap mode 0.
- IDLE: cap_valid ignored. cap_en=1 -> RUN next cycle; on that transition clear capture address, cap_count, cap_overflow, cap_wrapped, flush FIFO, latch cap_wrap.
- RUN: cap_en=0 -> IDLE next cycle, FIFO contents discarded, counters/flags hold for readback. Stop mode: when cap_count reaches 2^ADDR_W -> DONE in that same cycle's next state.
- DONE: no capture writes, cap_valid ignored (not overflow), FIFO flushed; cap_en=0 -> IDLE.
- Push: in RUN, cap_valid writes cap_data into FIFO. If FIFO full and no pop that cycle -> event dropped, cap_overflow set. Full with simultaneous pop -> push accepted.
- Arbitration, fixed priority, one write per cycle:
  - host_we=1 at cycle N -> ram_we=1 at N+1 with host_waddr/host_wdata. Host writes accepted in every state, never dropped, never stalled.
  - Else FIFO non-empty and state RUN -> pop head, ram_we=1 next cycle at capture address; capture address +1 (wraps 2^ADDR_W-1 -> 0), cap_count +1 (saturating).
  - Minimum capture latency: cap_valid at N -> ram_we at N+2 (push N, pop N+1).
- Wrap mode: address wraps; on first write after address 2^ADDR_W-1, cap_wrapped set; cap_count saturates at 2^ADDR_W; session never enters DONE.
- Ordering: capture events written in arrival order; no reordering across host writes.
- ram_we deasserted every cycle with no grant; ram_waddr/ram_wdata hold last values.
- rst mid-session: immediate return to reset values next cycle, in-flight write cancelled (ram_we=0).

Test Plan:
- Host write only: rst, cap_en=0, host_we pulse addr 0x0123 data 0xDEADBEEF -> next cycle ram_we=1, ram_waddr=0x0123, ram_wdata=0xDEADBEEF; cap_count stays 0.
- Basic capture: cap_en=1, then 3 cap_valid pulses data 0xA1,0xA2,0xA3 spaced 2 cycles -> writes to addr 0,1,2 each 2 cycles after its strobe; cap_count=3, cap_state=1.
- Conflict: cap_valid and host_we same cycle, then host_we on following 3 cycles -> host writes first on 4 consecutive cycles, capture word lands at addr 0 on cycle 6; no overflow.
- Overflow: FIFO_DEPTH=4, hold host_we high 8 cycles while cap_valid on 6 consecutive cycles -> 4 buffered, 2 dropped, cap_overflow=1, later addresses 0..3 get first 4 events in order.
- Stop on full (ADDR_W=4): cap_wrap=0, 20 events -> 16 writes to addr 0..15, cap_count=16, cap_state=2, remaining events ignored, cap_overflow=0; cap_en=0 -> cap_state=0.
- Wrap (ADDR_W=4): cap_wrap=1, 18 events -> 17th/18th written at addr 0,1, cap_wrapped=1, cap_count=16; assert rst mid-burst -> next cycle ram_we=0, all flags/counters 0.
